// File: rtl/rx_packet_framer.sv
// Packet framer: turns decoded symbols into a framed flit stream in a FWFT FIFO,
// with side-band credit/ACK pulses and error/overflow reporting.
module rx_packet_framer #(
    parameter int unsigned PKT_LEN_W  = 7,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 dec_done,
    input  logic [39:0]          dec_flit,
    input  logic [2:0]           dec_comma_sel,
    input  logic                 dec_err,
    input  logic [PKT_LEN_W-1:0] dec_pkt_size,
    output logic                 out_valid,
    output logic [39:0]          out_flit,
    output logic                 out_last,
    output logic                 out_poison,
    input  logic                 out_ready,
    output logic                 cred_vc0,
    output logic                 cred_vc1,
    output logic                 ack_valid,
    output logic                 ack_vc,
    output logic [1:0]           ack_id,
    output logic [4:0]           ack_req,
    output logic                 pkt_done,
    output logic                 pkt_err,
    output logic [15:0]          pkt_count,
    output logic [7:0]           err_count,
    output logic                 overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [2:0] SYM_START = 3'd0;
    localparam logic [2:0] SYM_END   = 3'd1;
    localparam logic [2:0] SYM_CRED0 = 3'd2;
    localparam logic [2:0] SYM_CRED1 = 3'd3;
    localparam logic [2:0] SYM_ACK   = 3'd4;
    localparam logic [2:0] SYM_DATA  = 3'd5;

    typedef enum logic [2:0] {IDLE, HEADER, BODY, WAIT_END, DROP} state_t;

    typedef struct packed {
        logic        poison;
        logic        last;
        logic [39:0] flit;
    } entry_t;

    localparam entry_t POISON_ENTRY = '{poison: 1'b1, last: 1'b1, flit: 40'h0};

    state_t               state, fsm_nxt, state_nxt;
    logic [PKT_LEN_W-1:0] rem, rem_nxt;
    entry_t               mem [FIFO_DEPTH];
    entry_t               head, push_entry;
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 fifo_full, fifo_empty, pop, push_req, push, drop_c;
    logic                 bad_sym, fsm_err, err_c, done_c, cred0_c, cred1_c, ack_c;

    // FIFO status and FWFT head; outputs forced to zero while empty
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = mem[rd_ptr[AW-1:0]];
    assign out_valid  = !fifo_empty;
    assign out_flit   = out_valid ? head.flit : 40'h0;
    assign out_last   = out_valid & head.last;
    assign out_poison = out_valid & head.poison;
    assign pop        = out_valid & out_ready;
    assign drop_c     = push_req & fifo_full & ~pop;
    assign push       = push_req & ~drop_c;
    assign bad_sym    = dec_err | (dec_comma_sel[2] & dec_comma_sel[1]);

    // Framing FSM next state, FIFO write request and pulse sources
    always_comb begin
        fsm_nxt    = state;
        rem_nxt    = rem;
        push_req   = 1'b0;
        push_entry = '0;
        fsm_err    = 1'b0;
        done_c     = 1'b0;
        cred0_c    = 1'b0;
        cred1_c    = 1'b0;
        ack_c      = 1'b0;
        if (dec_done) begin
            if (bad_sym) begin
                if (state != DROP) begin
                    fsm_err = 1'b1;
                    fsm_nxt = DROP;
                    if (state == BODY) begin
                        push_req   = 1'b1;
                        push_entry = POISON_ENTRY;
                    end
                end
            end else begin
                case (dec_comma_sel)
                    SYM_CRED0: cred0_c = 1'b1;
                    SYM_CRED1: cred1_c = 1'b1;
                    SYM_ACK:   ack_c   = 1'b1;
                    SYM_START: begin
                        fsm_err = (state inside {HEADER, BODY, WAIT_END});
                        if (state == BODY) begin
                            push_req   = 1'b1;
                            push_entry = POISON_ENTRY;
                        end
                        fsm_nxt = HEADER;
                    end
                    SYM_END: begin
                        case (state)
                            HEADER: begin
                                fsm_err = 1'b1;
                                fsm_nxt = IDLE;
                            end
                            BODY: begin
                                fsm_err    = 1'b1;
                                push_req   = 1'b1;
                                push_entry = POISON_ENTRY;
                                fsm_nxt    = IDLE;
                            end
                            WAIT_END: begin
                                done_c  = 1'b1;
                                fsm_nxt = IDLE;
                            end
                            DROP:    fsm_nxt = IDLE;
                            default: ;
                        endcase
                    end
                    SYM_DATA: begin
                        case (state)
                            IDLE: fsm_err = 1'b1;
                            HEADER: begin
                                push_req        = 1'b1;
                                push_entry.flit = dec_flit;
                                push_entry.last = (dec_pkt_size == '0);
                                rem_nxt         = dec_pkt_size;
                                fsm_nxt         = (dec_pkt_size == '0) ? WAIT_END : BODY;
                            end
                            BODY: begin
                                push_req        = 1'b1;
                                push_entry.flit = dec_flit;
                                push_entry.last = (rem <= PKT_LEN_W'(1));
                                rem_nxt         = (rem == '0) ? rem : rem - PKT_LEN_W'(1);
                                if (rem <= PKT_LEN_W'(1)) fsm_nxt = WAIT_END;
                            end
                            WAIT_END: begin
                                fsm_err = 1'b1;
                                fsm_nxt = IDLE;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    // A dropped FIFO write overrides the FSM decision
    assign state_nxt = drop_c ? DROP : fsm_nxt;
    assign err_c     = fsm_err | drop_c;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            rem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
    end

    // Registered pulses, ACK fields and counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cred_vc0  <= 1'b0;
            cred_vc1  <= 1'b0;
            ack_valid <= 1'b0;
            ack_vc    <= 1'b0;
            ack_id    <= 2'd0;
            ack_req   <= 5'd0;
            pkt_done  <= 1'b0;
            pkt_err   <= 1'b0;
            pkt_count <= 16'd0;
            err_count <= 8'd0;
            overflow  <= 1'b0;
        end else begin
            cred_vc0  <= cred0_c;
            cred_vc1  <= cred1_c;
            ack_valid <= ack_c;
            if (ack_c) begin
                ack_vc  <= dec_flit[39];
                ack_id  <= dec_flit[38:37];
                ack_req <= dec_flit[36:32];
            end
            pkt_done <= done_c;
            pkt_err  <= err_c;
            if (done_c) pkt_count <= pkt_count + 16'd1;
            if (err_c && err_count != 8'hFF) err_count <= err_count + 8'd1;
            if (drop_c) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rx_packet_framer.sv
// Directed self-checking bench for rx_packet_framer with hand-computed expectations.
module tb_rx_packet_framer;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dec_done;
    logic [39:0] dec_flit;
    logic [2:0]  dec_comma_sel;
    logic        dec_err;
    logic [6:0]  dec_pkt_size;
    logic        out_valid;
    logic [39:0] out_flit;
    logic        out_last;
    logic        out_poison;
    logic        out_ready;
    logic        cred_vc0, cred_vc1;
    logic        ack_valid, ack_vc;
    logic [1:0]  ack_id;
    logic [4:0]  ack_req;
    logic        pkt_done, pkt_err;
    logic [15:0] pkt_count;
    logic [7:0]  err_count;
    logic        overflow;

    localparam logic [2:0] S_START = 3'd0;
    localparam logic [2:0] S_END   = 3'd1;
    localparam logic [2:0] S_CRED0 = 3'd2;
    localparam logic [2:0] S_CRED1 = 3'd3;
    localparam logic [2:0] S_ACK   = 3'd4;
    localparam logic [2:0] S_DATA  = 3'd5;

    int checks   = 0;
    int failures = 0;
    logic [41:0] popped [$];

    rx_packet_framer dut (
        .CLK(CLK), .nRST(nRST), .dec_done(dec_done), .dec_flit(dec_flit),
        .dec_comma_sel(dec_comma_sel), .dec_err(dec_err), .dec_pkt_size(dec_pkt_size),
        .out_valid(out_valid), .out_flit(out_flit), .out_last(out_last),
        .out_poison(out_poison), .out_ready(out_ready), .cred_vc0(cred_vc0),
        .cred_vc1(cred_vc1), .ack_valid(ack_valid), .ack_vc(ack_vc), .ack_id(ack_id),
        .ack_req(ack_req), .pkt_done(pkt_done), .pkt_err(pkt_err),
        .pkt_count(pkt_count), .err_count(err_count), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    // Record every head that will be popped at the next rising edge
    always @(negedge CLK) begin
        if (nRST && out_valid && out_ready) popped.push_back({out_poison, out_last, out_flit});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one symbol for one cycle; returns just after the capturing edge
    task automatic sym(input logic [2:0] c, input logic [39:0] f, input logic [6:0] sz,
                       input logic e);
        dec_done = 1'b1; dec_comma_sel = c; dec_flit = f; dec_pkt_size = sz; dec_err = e;
        @(posedge CLK); #1;
        dec_done = 1'b0; dec_err = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic exp_entry(input string tag, input logic p, input logic l, input logic [39:0] f);
        chk({tag, "_present"}, 64'(popped.size() != 0), 64'd1);
        if (popped.size() != 0) chk(tag, 64'(popped.pop_front()), 64'({p, l, f}));
    endtask

    initial begin
        nRST = 1'b0; dec_done = 1'b0; dec_flit = '0; dec_comma_sel = '0;
        dec_err = 1'b0; dec_pkt_size = '0; out_ready = 1'b1;
        #3;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_flit", 64'(out_flit), 64'd0);
        chk("rst_pulses", 64'({cred_vc0, cred_vc1, ack_valid, pkt_done, pkt_err}), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        @(posedge CLK); #1; nRST = 1'b1;
        idle(1);

        // Three-flit packet streamed straight out
        sym(S_START, 40'h0, 7'd0, 1'b0);
        sym(S_DATA, 40'h01_0000_00A0, 7'd2, 1'b0);
        sym(S_DATA, 40'h01_0000_00A1, 7'd0, 1'b0);
        sym(S_DATA, 40'h01_0000_00A2, 7'd0, 1'b0);
        sym(S_END, 40'h0, 7'd0, 1'b0);
        chk("p1_done", 64'(pkt_done), 64'd1);
        chk("p1_err", 64'(pkt_err), 64'd0);
        chk("p1_count", 64'(pkt_count), 64'd1);
        idle(2);
        chk("p1_done_pulse", 64'(pkt_done), 64'd0);
        exp_entry("p1_e0", 1'b0, 1'b0, 40'h01_0000_00A0);
        exp_entry("p1_e1", 1'b0, 1'b0, 40'h01_0000_00A1);
        exp_entry("p1_e2", 1'b0, 1'b1, 40'h01_0000_00A2);

        // Header-only packet, then END in IDLE is silent
        sym(S_START, 40'h0, 7'd0, 1'b0);
        sym(S_DATA, 40'h02_0000_00B0, 7'd0, 1'b0);
        sym(S_END, 40'h0, 7'd0, 1'b0);
        chk("p2_done", 64'(pkt_done), 64'd1);
        chk("p2_count", 64'(pkt_count), 64'd2);
        sym(S_END, 40'h0, 7'd0, 1'b0);
        chk("p2_idle", 64'({pkt_done, pkt_err}), 64'd0);
        idle(2);
        exp_entry("p2_e0", 1'b0, 1'b1, 40'h02_0000_00B0);

        // START mid-body aborts with a poison entry; next DATA is a header
        sym(S_START, 40'h0, 7'd0, 1'b0);
        sym(S_DATA, 40'h03_0000_00C0, 7'd3, 1'b0);
        sym(S_DATA, 40'h03_0000_00C1, 7'd0, 1'b0);
        sym(S_START, 40'h0, 7'd0, 1'b0);
        chk("p3_abort_err", 64'(pkt_err), 64'd1);
        sym(S_DATA, 40'h03_0000_00D0, 7'd0, 1'b0);
        chk("p3_hdr_err", 64'(pkt_err), 64'd0);
        sym(S_END, 40'h0, 7'd0, 1'b0);
        chk("p3_done", 64'(pkt_done), 64'd1);
        chk("p3_err_count", 64'(err_count), 64'd1);
        idle(2);
        exp_entry("p3_e0", 1'b0, 1'b0, 40'h03_0000_00C0);
        exp_entry("p3_e1", 1'b0, 1'b0, 40'h03_0000_00C1);
        exp_entry("p3_poison", 1'b1, 1'b1, 40'h0);
        exp_entry("p3_hdr", 1'b0, 1'b1, 40'h03_0000_00D0);

        // Credit and ACK symbols interleaved inside a packet
        sym(S_START, 40'h0, 7'd0, 1'b0);
        sym(S_DATA, 40'h04_0000_00E0, 7'd2, 1'b0);
        sym(S_CRED1, 40'h0, 7'd0, 1'b0);
        chk("p4_cred", 64'({cred_vc1, cred_vc0}), 64'b10);
        sym(S_ACK, 40'hA5_DEAD_BEEF, 7'd0, 1'b0);
        chk("p4_ack", 64'({ack_valid, ack_vc, ack_id, ack_req}), 64'({1'b1, 1'b1, 2'd1, 5'd5}));
        chk("p4_cred_pulse", 64'(cred_vc1), 64'd0);
        sym(S_DATA, 40'h04_0000_00E1, 7'd0, 1'b0);
        chk("p4_ack_pulse", 64'(ack_valid), 64'd0);
        sym(S_CRED0, 40'h0, 7'd0, 1'b0);
        chk("p4_cred0", 64'({cred_vc1, cred_vc0}), 64'b01);
        sym(S_DATA, 40'h04_0000_00E2, 7'd0, 1'b0);
        sym(S_END, 40'h0, 7'd0, 1'b0);
        chk("p4_done", 64'(pkt_done), 64'd1);
        chk("p4_count", 64'(pkt_count), 64'd4);
        idle(2);
        exp_entry("p4_e0", 1'b0, 1'b0, 40'h04_0000_00E0);
        exp_entry("p4_e1", 1'b0, 1'b0, 40'h04_0000_00E1);
        exp_entry("p4_e2", 1'b0, 1'b1, 40'h04_0000_00E2);
        chk("p4_drained", 64'(popped.size()), 64'd0);

        // Reset in the middle of a packet discards the FIFO
        out_ready = 1'b0;
        sym(S_START, 40'h0, 7'd0, 1'b0);
        sym(S_DATA, 40'h05_0000_00F0, 7'd3, 1'b0);
        sym(S_DATA, 40'h05_0000_00F1, 7'd0, 1'b0);
        chk("r_valid_before", 64'(out_valid), 64'd1);
        nRST = 1'b0;
        #2;
        chk("r_valid", 64'(out_valid), 64'd0);
        chk("r_counts", 64'({pkt_count, err_count}), 64'd0);
        @(posedge CLK); #1; nRST = 1'b1;
        idle(2);
        chk("r_no_poison", 64'(out_valid), 64'd0);

        // Nine-flit packet into an eight-deep FIFO with no consumer
        sym(S_START, 40'h0, 7'd0, 1'b0);
        sym(S_DATA, 40'h06_0000_0100, 7'd8, 1'b0);
        for (int i = 1; i < 8; i++) sym(S_DATA, 40'h06_0000_0100 + 40'(i), 7'd0, 1'b0);
        chk("ovf_before", 64'({overflow, pkt_err}), 64'd0);
        sym(S_DATA, 40'h06_0000_0108, 7'd0, 1'b0);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_err", 64'(pkt_err), 64'd1);
        chk("ovf_err_count", 64'(err_count), 64'd1);
        sym(S_END, 40'h0, 7'd0, 1'b0);
        chk("ovf_end", 64'({pkt_done, pkt_err}), 64'd0);
        out_ready = 1'b1;
        idle(10);
        for (int i = 0; i < 8; i++)
            exp_entry($sformatf("ovf_e%0d", i), 1'b0, 1'b0, 40'h06_0000_0100 + 40'(i));
        chk("ovf_drained", 64'(popped.size()), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);
        sym(S_DATA, 40'h0, 7'd0, 1'b0);
        chk("ovf_idle", 64'(pkt_err), 64'd1);

        // Decode error mid-body: poison, then silent drop until END
        sym(S_START, 40'h0, 7'd0, 1'b0);
        sym(S_DATA, 40'h07_0000_0200, 7'd3, 1'b0);
        sym(S_DATA, 40'h07_0000_0201, 7'd0, 1'b0);
        sym(S_DATA, 40'h07_0000_0202, 7'd0, 1'b1);
        chk("de_err", 64'(pkt_err), 64'd1);
        sym(S_DATA, 40'h07_0000_0203, 7'd0, 1'b0);
        chk("de_drop", 64'(pkt_err), 64'd0);
        sym(S_END, 40'h0, 7'd0, 1'b0);
        chk("de_end", 64'({pkt_done, pkt_err}), 64'd0);
        idle(2);
        exp_entry("de_e0", 1'b0, 1'b0, 40'h07_0000_0200);
        exp_entry("de_e1", 1'b0, 1'b0, 40'h07_0000_0201);
        exp_entry("de_poison", 1'b1, 1'b1, 40'h0);
        chk("de_drained", 64'(popped.size()), 64'd0);
        sym(S_DATA, 40'h0, 7'd0, 1'b0);
        chk("de_idle", 64'(pkt_err), 64'd1);
        chk("de_err_count", 64'(err_count), 64'd4);
        sym(S_ACK, 40'hFF_0000_0000, 7'd0, 1'b1);
        chk("multi_err", 64'({pkt_err, ack_valid}), 64'b10);
        chk("multi_count", 64'(err_count), 64'd5);
        sym(S_END, 40'h0, 7'd0, 1'b0);
        sym(3'd6, 40'h0, 7'd0, 1'b0);
        chk("inv_err", 64'(pkt_err), 64'd1);
        chk("inv_count", 64'(err_count), 64'd6);
        sym(S_END, 40'h0, 7'd0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            sym(S_DATA, 40'h0, 7'd0, 1'b1);
            sym(S_END, 40'h0, 7'd0, 1'b0);
        end
        chk("sat_count", 64'(err_count), 64'd255);
        chk("sat_pkt_count", 64'(pkt_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_packet_framer.md
RX_PACKET_FRAMER -- requirements
Module: rx_packet_framer

Interface
REQ-001 The block SHALL have parameter PKT_LEN_W, default 7, the width of the remaining-flit count.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, the output FIFO depth; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have these ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- dec_done  in  1  decoded symbol valid this cycle
- dec_flit  in  40  flit; [39] vc, [38:37] id, [36:32] req, [31:0] payload
- dec_comma_sel  in  3  symbol class; 0 START, 1 END, 2 GRTCRED0, 3 GRTCRED1, 4 ACK, 5 DATA, 6–7 invalid
- dec_err  in  1  decode error on this symbol
- dec_pkt_size  in  PKT_LEN_W  data flits remaining after the header flit; valid with the header flit
- out_valid  out  1  FIFO head valid
- out_flit  out  40  FIFO head flit
- out_last  out  1  head is the last entry of its packet
- out_poison  out  1  head terminates an aborted packet
- out_ready  in  1  consumer pops the head when out_valid is high
- cred_vc0, cred_vc1  out  1 each  one-cycle credit-grant pulses
- ack_valid  out  1  one-cycle ACK pulse
- ack_vc  out  1  ACK vc field
- ack_id  out  2  ACK id field
- ack_req  out  5  ACK req field
- pkt_done  out  1  one-cycle pulse when a packet completes cleanly
- pkt_err  out  1  one-cycle pulse on any framing, decode or overflow error
- pkt_count  out  16  count of clean packets, wraps modulo 2^16
- err_count  out  8  count of pkt_err pulses, saturates at 255
- overflow  out  1  sticky flag; set on any dropped FIFO write, cleared only by reset

Function
REQ-004 The block SHALL ignore every input cycle in which dec_done=0.
REQ-005 The FSM SHALL have the states IDLE, HEADER, BODY, WAIT_END and DROP, and SHALL reset to IDLE.
REQ-006 IDLE: START SHALL go to HEADER; DATA SHALL raise pkt_err and stay in IDLE; END SHALL be ignored.
REQ-007 HEADER: DATA SHALL write the flit to the FIFO and load rem=dec_pkt_size.
- If dec_pkt_size=0, the entry SHALL be written with last=1 and the FSM SHALL go to WAIT_END.
- Otherwise the entry SHALL be written with last=0 and the FSM SHALL go to BODY.
REQ-008 BODY: each DATA SHALL write the flit and decrement rem; when rem=1 before the decrement, the entry SHALL be written with last=1 and the FSM SHALL go to WAIT_END.
REQ-009 WAIT_END: END SHALL pulse pkt_done, increment pkt_count and go to IDLE; DATA SHALL raise pkt_err and go to IDLE.
REQ-010 Abort: START while in HEADER, BODY or WAIT_END SHALL raise pkt_err and go to HEADER (resynchronise).
- If the abort occurs in BODY, a poison entry SHALL be written: flit=0, last=1, poison=1.
REQ-011 END received in HEADER or BODY SHALL raise pkt_err and go to IDLE, with a poison entry written if in BODY.
REQ-012 dec_err=1, or dec_comma_sel of 6 or 7, with dec_done=1 SHALL raise pkt_err and go to DROP.
- A poison entry SHALL be written if the FSM was in BODY.
- The flit on that cycle SHALL NOT be written.
REQ-013 DROP SHALL discard all symbols until END (go to IDLE) or START (go to HEADER), with no further pkt_err.
REQ-014 GRTCRED0/GRTCRED1 SHALL pulse cred_vc0/cred_vc1 on the next cycle in every state, including DROP, and SHALL NOT change the FSM state.
REQ-015 ACK SHALL pulse ack_valid on the next cycle with ack_vc/ack_id/ack_req taken from dec_flit[39:32], SHALL NOT change the FSM state, and SHALL NOT be issued when dec_err=1.
REQ-016 All pulse outputs SHALL be registered, one cycle after the triggering symbol.
REQ-017 The FIFO SHALL be first-word-fall-through: a write at edge N SHALL make out_valid high after edge N when the FIFO was empty.
REQ-018 A pop SHALL occur when out_valid & out_ready; a simultaneous push and pop SHALL be legal at any occupancy.
- A push into a full FIFO SHALL succeed only if a pop occurs in the same cycle.
REQ-019 A push into a full FIFO with no pop SHALL drop the entry, set overflow, raise pkt_err and go to DROP.
- A poison entry SHALL NOT be written on this path.
REQ-020 The FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
- Full SHALL be defined as MSBs differing with the lower bits equal.
- Empty SHALL be defined as the pointers being equal.
REQ-021 pkt_err from multiple causes in one cycle SHALL produce a single pulse and a single err_count increment.

Reset
REQ-022 When nRST is asserted, the FSM SHALL be IDLE and rem SHALL be 0.
REQ-023 When nRST is asserted, the FIFO SHALL be empty.
REQ-024 When nRST is asserted, all outputs SHALL be 0, including out_valid, out_flit, the pulse outputs, pkt_count, err_count and overflow.
REQ-025 Reset asserted mid-packet SHALL discard FIFO contents, with no poison entry emitted.

Verification
REQ-026 The bench SHALL cover: START, DATA size=2, DATA, DATA, END with out_ready=1 -> 3 entries, only the third with out_last=1; pkt_done one cycle after END; pkt_count=1.
REQ-027 The bench SHALL cover: START, DATA size=0, END -> 1 entry with out_last=1; pkt_done pulses; FSM returns to IDLE.
REQ-028 The bench SHALL cover: START, DATA size=3, DATA, START -> pkt_err; poison entry (last=1, poison=1) after 2 data entries; the next DATA is accepted as a header.
REQ-029 The bench SHALL cover: out_ready=0 with FIFO_DEPTH=8 and packet size 9 -> 8 entries stored; the 9th is dropped; overflow=1; err_count=1; END returns the FSM to IDLE.
REQ-030 The bench SHALL cover: GRTCRED1 and ACK with dec_flit[39:32]=8'hA5 interleaved mid-packet -> cred_vc1 pulse, then ack_valid with vc=1, id=1, req=5; packet content and last flag unaffected.
REQ-031 The bench SHALL cover: DATA with dec_err=1 in BODY -> poison entry; DROP discards the rest of the packet; END -> IDLE; 256 such errors -> err_count holds at 255.
